// File: rtl/ex_muldiv_if.sv
// Handshake and writeback bundle between the EX slot and the iterative M-extension unit.
// The master drives the instruction; the slave returns stall, status and the registered result.
interface ex_muldiv_if #(
  parameter int XLEN = 32
);
  logic            start_i;
  logic [2:0]      op_i;
  logic [XLEN-1:0] opr1_i;
  logic [XLEN-1:0] opr2_i;
  logic [4:0]      wd_i;
  logic            flush_i;
  logic            ex_stall;
  logic            done_o;
  logic [4:0]      wd_o;
  logic            wreg_o;
  logic [XLEN-1:0] wdata_o;
  logic            busy_o;

  modport master (
    output start_i, op_i, opr1_i, opr2_i, wd_i, flush_i,
    input  ex_stall, done_o, wd_o, wreg_o, wdata_o, busy_o
  );

  modport slave (
    input  start_i, op_i, opr1_i, opr2_i, wd_i, flush_i,
    output ex_stall, done_o, wd_o, wreg_o, wdata_o, busy_o
  );
endinterface

// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M execute unit: shift-add multiplier retiring MUL_STEP bits per cycle and a
// restoring divider retiring one quotient bit per cycle, sharing one 2*XLEN accumulator.
module ex_muldiv #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1
) (
  input  logic         clk,
  input  logic         rst,
  ex_muldiv_if.slave   bus
);

  localparam int MUL_CYC = XLEN / MUL_STEP;
  localparam int CW      = $clog2(XLEN + 1);

  typedef enum logic [2:0] {IDLE, MUL, DIV, FIX, DONE} state_e;

  state_e            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [4:0]        wd_q, wd_d;
  logic [XLEN-1:0]   opa_q, opa_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              negRes_q, negRes_d;
  logic              negRem_q, negRem_d;
  logic              done_q, done_d;
  logic [4:0]        wdOut_q, wdOut_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;

  logic              s1Signed, s2Signed, neg1, neg2;
  logic              divZero, divOvf, isSpecial;
  logic [XLEN-1:0]   mag1, mag2, specialVal;

  // Decode the incoming instruction: operand magnitudes, result signs and the no-iteration cases.
  always_comb begin
    s1Signed   = (bus.op_i == 3'd1) || (bus.op_i == 3'd2) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    s2Signed   = (bus.op_i == 3'd1) || (bus.op_i == 3'd4) || (bus.op_i == 3'd6);
    neg1       = s1Signed & bus.opr1_i[XLEN-1];
    neg2       = s2Signed & bus.opr2_i[XLEN-1];
    mag1       = neg1 ? -bus.opr1_i : bus.opr1_i;
    mag2       = neg2 ? -bus.opr2_i : bus.opr2_i;
    divZero    = (bus.opr2_i == '0);
    divOvf     = bus.op_i[2] & ~bus.op_i[0] &
                 (bus.opr1_i == {1'b1, {(XLEN-1){1'b0}}}) & (bus.opr2_i == '1);
    isSpecial  = bus.op_i[2] & (divZero | divOvf);
    specialVal = '0;
    if (divZero) begin
      specialVal = bus.op_i[1] ? bus.opr1_i : '1;
    end else begin
      specialVal = bus.op_i[1] ? '0 : bus.opr1_i;
    end
  end

  logic [XLEN+MUL_STEP-1:0] mulPart, mulSum;
  logic [XLEN:0]            divTrial;
  logic [2*XLEN-1:0]        prodFix;
  logic [XLEN-1:0]          fixResult;

  // One iteration of either datapath, plus the sign fix-up applied in FIX.
  always_comb begin
    mulPart  = {{MUL_STEP{1'b0}}, opa_q} * {{XLEN{1'b0}}, acc_q[MUL_STEP-1:0]};
    mulSum   = {{MUL_STEP{1'b0}}, acc_q[2*XLEN-1:XLEN]} + mulPart;
    divTrial = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]} - {1'b0, opa_q};
    prodFix  = negRes_q ? -acc_q : acc_q;
    fixResult = '0;
    unique case (op_q)
      3'd0:          fixResult = prodFix[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fixResult = prodFix[2*XLEN-1:XLEN];
      3'd4, 3'd5:    fixResult = negRes_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
      default:       fixResult = negRem_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  logic [XLEN-1:0] resultVal;

  // Next-state logic; a flush wins over everything and also blocks capture in IDLE.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    wd_d      = wd_q;
    opa_d     = opa_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    negRes_d  = negRes_q;
    negRem_d  = negRem_q;
    resultVal = '0;
    done_d    = 1'b0;
    wdOut_d   = '0;
    wdata_d   = '0;
    if (bus.flush_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (bus.start_i) begin
            op_d     = bus.op_i;
            wd_d     = bus.wd_i;
            negRes_d = neg1 ^ neg2;
            negRem_d = neg1;
            opa_d    = bus.op_i[2] ? mag2 : mag1;
            acc_d    = {{XLEN{1'b0}}, (bus.op_i[2] ? mag1 : mag2)};
            cnt_d    = bus.op_i[2] ? CW'(XLEN - 1) : CW'(MUL_CYC - 1);
            if (isSpecial) begin
              state_d   = DONE;
              resultVal = specialVal;
            end else begin
              state_d = bus.op_i[2] ? DIV : MUL;
            end
          end
        end
        MUL: begin
          acc_d = {mulSum, acc_q[XLEN-1:MUL_STEP]};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
        DIV: begin
          acc_d = divTrial[XLEN] ? {acc_q[2*XLEN-2:0], 1'b0}
                                 : {divTrial[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == '0) state_d = FIX;
        end
        FIX: begin
          state_d   = DONE;
          resultVal = fixResult;
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    if (state_d == DONE) begin
      done_d  = 1'b1;
      wdOut_d = wd_d;
      wdata_d = resultVal;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      wd_q     <= '0;
      opa_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      negRes_q <= 1'b0;
      negRem_q <= 1'b0;
      done_q   <= 1'b0;
      wdOut_q  <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      wd_q     <= wd_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      negRes_q <= negRes_d;
      negRem_q <= negRem_d;
      done_q   <= done_d;
      wdOut_q  <= wdOut_d;
      wdata_q  <= wdata_d;
    end
  end

  // Stall drops in DONE so the pipeline advances on the same edge the result retires.
  assign bus.ex_stall = (bus.start_i && (state_q == IDLE)) || ((state_q != IDLE) && (state_q != DONE));
  assign bus.busy_o   = (state_q != IDLE);
  assign bus.done_o   = done_q;
  assign bus.wreg_o   = done_q;
  assign bus.wd_o     = wdOut_q;
  assign bus.wdata_o  = wdata_q;

endmodule
